// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the writeback queue: default widths, the queue entry layout
// and the "does this entry write the register file" predicate used by retire and forwarding.
package writeback_queue_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
    logic               wr_en;
    logic               flag;
  } wb_entry_t;

  // x0 is hardwired to zero, so an entry only counts as a register write when rd is non-zero.
  function automatic logic writes_rf(input logic wr_en, input logic rd_nonzero);
    return wr_en && rd_nonzero;
  endfunction

endpackage

// File: rtl/writeback_queue_fwd_match.sv
// Youngest-match search over the valid queue entries for one decode source address.
// Walks from head (oldest) to tail so a later match overrides an earlier one.
module wb_fwd_match #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 2,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic [DEPTH*RADDR_W-1:0] ent_rd,
  input  logic [DEPTH*XLEN-1:0]    ent_data,
  input  logic [DEPTH-1:0]         ent_wr_en,
  input  logic [PTR_W-1:0]         rptr,
  input  logic [PTR_W:0]           count,
  input  logic [RADDR_W-1:0]       src_addr,
  output logic                     hit,
  output logic [XLEN-1:0]          data
);
  import writeback_queue_pkg::*;

  always_comb begin
    logic [PTR_W-1:0]   idx;
    logic [RADDR_W-1:0] rd;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    rd   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PTR_W'(k);
      rd  = ent_rd[idx*RADDR_W +: RADDR_W];
      if ((PTR_W+1)'(k) < count && writes_rf(ent_wr_en[idx], |rd) && rd == src_addr) begin
        hit  = 1'b1;
        data = ent_data[idx*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue between execute and the register-file write port, with decode-side hazard
// detection. Define WB_FORWARD_EN to forward pending results; otherwise decode stalls on a match.
module writeback_queue #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_data,
  input  logic               in_wr_en,
  input  logic               in_flag,
  input  logic               rf_busy,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]    rf_wr_data,
  output logic               flag_out,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic               fwd1_hit,
  output logic               fwd2_hit,
  output logic [XLEN-1:0]    fwd1_data,
  output logic [XLEN-1:0]    fwd2_data,
  output logic               stall_out
);
  import writeback_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [RADDR_W-1:0] rd_q    [DEPTH];
  logic [XLEN-1:0]    data_q  [DEPTH];
  logic               wr_en_q [DEPTH];
  logic               flag_q  [DEPTH];

  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_eff;

  logic               head_valid;
  logic [RADDR_W-1:0] head_rd;
  logic [XLEN-1:0]    head_data;
  logic               head_wr_en;
  logic               head_flag;
  logic               push;
  logic               pop;
  logic               match1;
  logic               match2;

  logic [DEPTH*RADDR_W-1:0] rd_flat;
  logic [DEPTH-1:0]         wr_en_flat;

  // While rst_n is low the stored state is about to be discarded, so present an empty queue.
  assign count_eff  = rst_n ? count : '0;
  assign in_ready   = (count_eff != (PTR_W+1)'(DEPTH));
  assign head_valid = (count_eff != '0);
  assign push       = in_valid && in_ready && rst_n;
  assign pop        = head_valid && !rf_busy;

  assign head_rd    = rd_q[rptr];
  assign head_data  = data_q[rptr];
  assign head_wr_en = wr_en_q[rptr];
  assign head_flag  = flag_q[rptr];

  assign rf_wr_en   = pop && writes_rf(head_wr_en, |head_rd);
  assign rf_wr_addr = head_rd;
  assign rf_wr_data = head_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      flag_out <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr     <= rptr + 1'b1;
        flag_out <= head_flag;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset: validity comes only from count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]    <= in_rd;
      data_q[wptr]  <= in_data;
      wr_en_q[wptr] <= in_wr_en;
      flag_q[wptr]  <= in_flag;
    end
  end

  always_comb begin
    rd_flat    = '0;
    wr_en_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_flat[i*RADDR_W +: RADDR_W] = rd_q[i];
      wr_en_flat[i]                 = wr_en_q[i];
    end
  end

`ifdef WB_FORWARD_EN
  logic [DEPTH*XLEN-1:0] data_flat;

  always_comb begin
    data_flat = '0;
    for (int i = 0; i < DEPTH; i++) data_flat[i*XLEN +: XLEN] = data_q[i];
  end

  wb_fwd_match #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH)) u_match1 (
    .ent_rd(rd_flat), .ent_data(data_flat), .ent_wr_en(wr_en_flat),
    .rptr(rptr), .count(count_eff), .src_addr(rs1_addr),
    .hit(match1), .data(fwd1_data)
  );

  wb_fwd_match #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH)) u_match2 (
    .ent_rd(rd_flat), .ent_data(data_flat), .ent_wr_en(wr_en_flat),
    .rptr(rptr), .count(count_eff), .src_addr(rs2_addr),
    .hit(match2), .data(fwd2_data)
  );

  assign fwd1_hit  = match1;
  assign fwd2_hit  = match2;
  assign stall_out = !in_ready;
`else
  // Data inputs are tied off, so the matchers' data outputs are constant zero.
  wb_fwd_match #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH)) u_match1 (
    .ent_rd(rd_flat), .ent_data('0), .ent_wr_en(wr_en_flat),
    .rptr(rptr), .count(count_eff), .src_addr(rs1_addr),
    .hit(match1), .data(fwd1_data)
  );

  wb_fwd_match #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH)) u_match2 (
    .ent_rd(rd_flat), .ent_data('0), .ent_wr_en(wr_en_flat),
    .rptr(rptr), .count(count_eff), .src_addr(rs2_addr),
    .hit(match2), .data(fwd2_data)
  );

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign stall_out = !in_ready || match1 || match2;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=2); expectations follow WB_FORWARD_EN if defined.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        in_wr_en;
  logic        in_flag;
  logic        rf_busy;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        flag_out;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic        stall_out;

  int n_cmp  = 0;
  int n_fail = 0;

  writeback_queue #(.XLEN(32), .RADDR_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .in_wr_en(in_wr_en), .in_flag(in_flag),
    .rf_busy(rf_busy), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .flag_out(flag_out), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic we, input logic fl);
    in_valid = v; in_rd = rd; in_data = d; in_wr_en = we; in_flag = fl;
  endtask

  initial begin
    rst_n = 1'b0; rf_busy = 1'b0; rs1_addr = '0; rs2_addr = '0;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // During reset, before any edge
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_stall", stall_out, 0);
    step();
    chk("rst_flag_out", flag_out, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_rf_wr_en", rf_wr_en, 0);
    chk("post_rst_fwd1", fwd1_hit, 0);
    chk("post_rst_fwd2", fwd2_hit, 0);
    chk("post_rst_stall", stall_out, 0);

    // Single write-through
    set_in(1'b1, 5'd3, 32'h11, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("single_wr_en", rf_wr_en, 1);
    chk("single_addr", rf_wr_addr, 3);
    chk("single_data", rf_wr_data, 32'h11);
    step();
    chk("single_drained_wr_en", rf_wr_en, 0);
    chk("single_drained_ready", in_ready, 1);

    // Fill while the write port is busy, third offer refused
    rf_busy = 1'b1;
    set_in(1'b1, 5'd1, 32'h21, 1'b1, 1'b0);
    step();
    chk("busy_one_ready", in_ready, 1);
    set_in(1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
    step();
    chk("busy_full_ready", in_ready, 0);
    chk("busy_full_wr_en", rf_wr_en, 0);
    set_in(1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    step();
    chk("busy_third_ready", in_ready, 0);
    in_valid = 1'b0;
    rf_busy = 1'b0;
    #1;
    chk("drain0_wr_en", rf_wr_en, 1);
    chk("drain0_addr", rf_wr_addr, 1);
    chk("drain0_data", rf_wr_data, 32'h21);
    step();
    chk("drain1_wr_en", rf_wr_en, 1);
    chk("drain1_addr", rf_wr_addr, 2);
    chk("drain1_data", rf_wr_data, 32'h22);
    chk("drain1_ready", in_ready, 1);
    step();
    chk("drain2_wr_en", rf_wr_en, 0);

    // Two pending writes to x5; youngest wins
    rf_busy = 1'b1;
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    set_in(1'b1, 5'd5, 32'hA, 1'b1, 1'b0);
    step();
    set_in(1'b1, 5'd5, 32'hB, 1'b1, 1'b0);
`ifdef WB_FORWARD_EN
    chk("fwd_one_hit", fwd1_hit, 1);
    chk("fwd_one_data", fwd1_data, 32'hA);
    chk("fwd_one_stall", stall_out, 0);
`else
    chk("fwd_one_hit", fwd1_hit, 0);
    chk("fwd_one_data", fwd1_data, 0);
    chk("fwd_one_stall", stall_out, 1);
`endif
    step();
    in_valid = 1'b0;
`ifdef WB_FORWARD_EN
    chk("fwd_two_hit", fwd1_hit, 1);
    chk("fwd_two_data", fwd1_data, 32'hB);
`else
    chk("fwd_two_hit", fwd1_hit, 0);
    chk("fwd_two_data", fwd1_data, 0);
`endif
    chk("fwd_two_stall", stall_out, 1);
    chk("fwd_rs2_nohit", fwd2_hit, 0);
    chk("fwd_rs2_data", fwd2_data, 0);
    rf_busy = 1'b0;
    #1;
    chk("fwd_drain0_data", rf_wr_data, 32'hA);
    step();
    chk("fwd_drain1_data", rf_wr_data, 32'hB);
    step();
    chk("fwd_empty_hit", fwd1_hit, 0);
    chk("fwd_empty_stall", stall_out, 0);

    // x0 destination: retires silently, carries its flag, never matches rs1=x0
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    set_in(1'b1, 5'd0, 32'h77, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("x0_no_wr_en", rf_wr_en, 0);
    chk("x0_no_hit", fwd1_hit, 0);
    chk("x0_no_stall", stall_out, 0);
    chk("x0_flag_before_pop", flag_out, 0);
    step();
    chk("x0_flag_after_pop", flag_out, 1);

    // wr_en=0 entry: no write, no match on its rd, flag reloads to 0
    rs1_addr = 5'd7;
    set_in(1'b1, 5'd7, 32'h99, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("nowr_wr_en", rf_wr_en, 0);
    chk("nowr_stall", stall_out, 0);
    chk("nowr_hit", fwd1_hit, 0);
    step();
    chk("nowr_flag", flag_out, 0);

    // Raise flag_out, fill the queue, then reset mid-flight
    rs1_addr = 5'd0;
    set_in(1'b1, 5'd8, 32'h88, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_flag", flag_out, 1);
    rf_busy = 1'b1;
    set_in(1'b1, 5'd9, 32'h90, 1'b1, 1'b1);
    step();
    set_in(1'b1, 5'd10, 32'hA0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    rf_busy = 1'b0;
    #1;
    chk("in_rst_ready", in_ready, 1);
    chk("in_rst_wr_en", rf_wr_en, 0);
    chk("in_rst_stall", stall_out, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("after_rst_flag", flag_out, 0);
    chk("after_rst_wr_en", rf_wr_en, 0);
    chk("after_rst_ready", in_ready, 1);
    step();
    chk("after_rst2_wr_en", rf_wr_en, 0);

    // Streaming push+pop: pointers wrap, order preserved, occupancy stays at one
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 1'b0);
      step();
      chk("stream_wr_en", rf_wr_en, 1);
      chk("stream_addr", rf_wr_addr, 64'(i + 1));
      chk("stream_data", rf_wr_data, 64'(32'h100 + 32'(i)));
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_wr_en", rf_wr_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
